// File: rtl/wave_serializer_if.sv
// Sample push handshake and serial audio output bundle for wave_serializer.
// The master side feeds samples; the slave side is the serializer.
interface wave_serializer_if #(
    parameter int WAVE_DEPTH = 8
);
    logic [WAVE_DEPTH-1:0] SampleIn;
    logic                  SampleValid;
    logic                  SampleReady;
    logic                  BitClock;
    logic                  WordSelect;
    logic                  SerialData;
    logic                  Underrun;

    modport master (
        output SampleIn, SampleValid,
        input  SampleReady, BitClock, WordSelect, SerialData, Underrun
    );

    modport slave (
        input  SampleIn, SampleValid,
        output SampleReady, BitClock, WordSelect, SerialData, Underrun
    );
endinterface

// File: rtl/wave_serializer.sv
// FIFO-buffered mono sample serializer: MSB-first, left then right slot, continuous frames.
// Define UNDERRUN_HOLD_EN to repeat the last sample on underrun instead of sending midscale.
module wave_serializer #(
    parameter int WAVE_DEPTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV    = 2
) (
    input  logic               Clock,
    input  logic               Reset,
    wave_serializer_if.slave   bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam int BIT_W = $clog2(2 * WAVE_DEPTH);
    localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0]      DIV_HALF = DIV_W'(CLK_DIV);
    localparam logic [BIT_W-1:0]      BIT_LAST = BIT_W'(2 * WAVE_DEPTH - 1);
    localparam logic [BIT_W-1:0]      BIT_HALF = BIT_W'(WAVE_DEPTH);
    localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [WAVE_DEPTH-1:0] MIDSCALE = {1'b1, {(WAVE_DEPTH-1){1'b0}}};

    typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t                  state_r;
    logic [WAVE_DEPTH-1:0]   mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]        count_r;
    logic [DIV_W-1:0]        div_cnt_r, div_nxt_s;
    logic [BIT_W-1:0]        bit_cnt_r, bit_nxt_s, slot_s;
    logic [WAVE_DEPTH-1:0]   sample_r, sample_nxt_s, shl_s, fill_s;
    logic                    bit_clock_r, word_select_r, serial_data_r, underrun_r;
    logic                    ready_s, empty_s, push_s, pop_s, underrun_s, shift_nxt_s;

`ifdef UNDERRUN_HOLD_EN
    logic [WAVE_DEPTH-1:0]   last_r;
    assign fill_s = last_r;
`else
    assign fill_s = MIDSCALE;
`endif

    assign ready_s         = (count_r != CNT_FULL);
    assign empty_s         = (count_r == '0);
    assign push_s          = bus.SampleValid & ready_s;
    assign bus.SampleReady = ready_s;
    assign bus.BitClock    = bit_clock_r;
    assign bus.WordSelect  = word_select_r;
    assign bus.SerialData  = serial_data_r;
    assign bus.Underrun    = underrun_r;

    // Next divider/bit/sample values and the pop/underrun decision for this cycle
    always_comb begin
        pop_s        = 1'b0;
        underrun_s   = 1'b0;
        div_nxt_s    = div_cnt_r;
        bit_nxt_s    = bit_cnt_r;
        sample_nxt_s = sample_r;
        shift_nxt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    pop_s        = 1'b1;
                    sample_nxt_s = mem_r[rd_ptr_r];
                    div_nxt_s    = '0;
                    bit_nxt_s    = '0;
                    shift_nxt_s  = 1'b1;
                end else begin
                    shift_nxt_s  = 1'b0;
                end
            end
            SHIFT: begin
                shift_nxt_s = 1'b1;
                if (div_cnt_r == DIV_LAST) begin
                    div_nxt_s = '0;
                    if (bit_cnt_r == BIT_LAST) begin
                        bit_nxt_s = '0;
                        if (!empty_s) begin
                            pop_s        = 1'b1;
                            sample_nxt_s = mem_r[rd_ptr_r];
                        end else begin
                            underrun_s   = 1'b1;
                            sample_nxt_s = fill_s;
                        end
                    end else begin
                        bit_nxt_s = bit_cnt_r + BIT_W'(1);
                    end
                end else begin
                    div_nxt_s = div_cnt_r + DIV_W'(1);
                end
            end
            default: begin
                shift_nxt_s = 1'b0;
            end
        endcase
    end

    // Both slots carry the same sample, so the bit position restarts at the right slot
    always_comb begin
        if (bit_nxt_s >= BIT_HALF) begin
            slot_s = bit_nxt_s - BIT_HALF;
        end else begin
            slot_s = bit_nxt_s;
        end
        shl_s = sample_nxt_s << slot_s;
    end

    // Sample storage write port
    always_ff @(posedge Clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= bus.SampleIn;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Serializer FSM, counters and registered serial outputs
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r       <= IDLE;
            div_cnt_r     <= '0;
            bit_cnt_r     <= '0;
            sample_r      <= '0;
            bit_clock_r   <= 1'b0;
            word_select_r <= 1'b0;
            serial_data_r <= 1'b0;
            underrun_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE:    state_r <= empty_s ? IDLE : SHIFT;
                SHIFT:   state_r <= SHIFT;
                default: state_r <= IDLE;
            endcase
            div_cnt_r     <= div_nxt_s;
            bit_cnt_r     <= bit_nxt_s;
            sample_r      <= sample_nxt_s;
            bit_clock_r   <= shift_nxt_s & (div_nxt_s >= DIV_HALF);
            word_select_r <= shift_nxt_s & (bit_nxt_s >= BIT_HALF);
            serial_data_r <= shift_nxt_s & shl_s[WAVE_DEPTH-1];
            underrun_r    <= underrun_s;
        end
    end

`ifdef UNDERRUN_HOLD_EN
    // Remember the most recently popped sample for underrun frames
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            last_r <= '0;
        end else if (pop_s) begin
            last_r <= sample_nxt_s;
        end else begin
            last_r <= last_r;
        end
    end
`endif

endmodule

// File: tb/tb_wave_serializer.sv
// Directed self-checking bench for wave_serializer at default parameters.
// Expected serial traces are rebuilt from the sample value and cycle position.
module tb_wave_serializer;
    logic Clock;
    logic Reset;
    int   err_cnt;
    int   chk_cnt;
    logic act;

    wave_serializer_if #(.WAVE_DEPTH(8)) bus ();

    wave_serializer #(.WAVE_DEPTH(8), .FIFO_DEPTH(4), .CLK_DIV(2)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] val);
        @(negedge Clock);
        bus.SampleIn    = val;
        bus.SampleValid = 1'b1;
        @(posedge Clock);
        #1;
        bus.SampleValid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b0;
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
    endtask

    // Captures one 64-cycle frame starting at the next falling edge
    task automatic run_frame(input string tag, input logic [7:0] samp, input logic exp_und);
        logic [63:0] bc, ws, sd, un, ebc, ews, esd, eun;
        for (int k = 0; k < 64; k++) begin
            @(negedge Clock);
            bc[6'(k)]  = bus.BitClock;
            ws[6'(k)]  = bus.WordSelect;
            sd[6'(k)]  = bus.SerialData;
            un[6'(k)]  = bus.Underrun;
            ebc[6'(k)] = ((k % 4) >= 2);
            ews[6'(k)] = ((k / 4) >= 8);
            esd[6'(k)] = samp[3'(7 - ((k / 4) % 8))];
            eun[6'(k)] = exp_und && (k == 0);
        end
        check_eq({tag, "_bclk"}, bc, ebc);
        check_eq({tag, "_ws"},   ws, ews);
        check_eq({tag, "_sd"},   sd, esd);
        check_eq({tag, "_und"},  un, eun);
    endtask

    initial begin
        logic [7:0] und_ff;
        logic [7:0] und_a5;
        err_cnt         = 0;
        chk_cnt         = 0;
        Reset           = 1'b0;
        bus.SampleIn    = 8'h00;
        bus.SampleValid = 1'b0;
`ifdef UNDERRUN_HOLD_EN
        und_ff = 8'hFF;
        und_a5 = 8'hA5;
`else
        und_ff = 8'h80;
        und_a5 = 8'h80;
`endif
        // Reset values
        repeat (2) @(negedge Clock);
        check_eq("rst_ready", 64'(bus.SampleReady), 64'd1);
        check_eq("rst_bclk",  64'(bus.BitClock),    64'd0);
        check_eq("rst_ws",    64'(bus.WordSelect),  64'd0);
        check_eq("rst_sd",    64'(bus.SerialData),  64'd0);
        check_eq("rst_und",   64'(bus.Underrun),    64'd0);
        Reset = 1'b1;

        // Five back-to-back pushes: one popped, four fill the FIFO
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        push(8'h55);
        @(negedge Clock);
        check_eq("full_ready", 64'(bus.SampleReady), 64'd0);
        repeat (60) @(negedge Clock);
        check_eq("full_ready_end", 64'(bus.SampleReady), 64'd0);
        @(negedge Clock);
        check_eq("pop_ready", 64'(bus.SampleReady), 64'd1);

        // Mid-frame reset at bit 5 with three samples queued
        repeat (22) @(negedge Clock);
        check_eq("mid_bclk", 64'(bus.BitClock),   64'd1);
        check_eq("mid_sd",   64'(bus.SerialData), 64'd0);
        Reset = 1'b0;
        #1;
        check_eq("abort_bclk",  64'(bus.BitClock),    64'd0);
        check_eq("abort_ws",    64'(bus.WordSelect),  64'd0);
        check_eq("abort_sd",    64'(bus.SerialData),  64'd0);
        check_eq("abort_ready", 64'(bus.SampleReady), 64'd1);
        repeat (3) @(negedge Clock);
        Reset = 1'b1;
        act = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            act = act | bus.SerialData | bus.BitClock | bus.WordSelect | bus.Underrun;
        end
        check_eq("quiet_after_rst", 64'(act), 64'd0);
        check_eq("quiet_ready", 64'(bus.SampleReady), 64'd1);

        // Single sample latency and frame, then underrun frame
        push(8'hA5);
        @(negedge Clock);
        check_eq("lat_pre_sd", 64'(bus.SerialData), 64'd0);
        run_frame("a5", 8'hA5, 1'b0);
        run_frame("a5_und", und_a5, 1'b1);

        // Two-sample stream followed by underrun
        do_reset();
        push(8'h01);
        push(8'hFF);
        run_frame("s01", 8'h01, 1'b0);
        run_frame("sff", 8'hFF, 1'b0);
        run_frame("sff_und", und_ff, 1'b1);

        // Push exactly on the frame-end pop with three queued
        do_reset();
        push(8'h3C);
        push(8'h96);
        push(8'h0F);
        push(8'hC3);
        repeat (61) @(negedge Clock);
        check_eq("occ3_ready_pre", 64'(bus.SampleReady), 64'd1);
        push(8'h5A);
        check_eq("occ3_ready_post", 64'(bus.SampleReady), 64'd1);
        run_frame("q96", 8'h96, 1'b0);
        run_frame("q0f", 8'h0F, 1'b0);
        run_frame("qc3", 8'hC3, 1'b0);
        run_frame("q5a", 8'h5A, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/wave_serializer.md
WAVE_SERIALIZER -- requirements
Module: wave_serializer

Interface
REQ-001 Parameters SHALL be, one per line:
  WAVE_DEPTH, 8, sample width in bits (>=2)
  FIFO_DEPTH, 4, sample FIFO entries (power of 2, >=2)
  CLK_DIV, 2, Clock cycles per BitClock half-period (>=1)
REQ-002 Ports SHALL be, one per line:
  Clock  input  1  single system clock, all logic on rising edge
  Reset  input  1  asynchronous, active-low reset
  SampleIn  input  WAVE_DEPTH  unsigned waveform sample
  SampleValid  input  1  SampleIn valid
  SampleReady  output  1  FIFO can accept a sample
  BitClock  output  1  serial bit clock
  WordSelect  output  1  slot select, 0=left, 1=right
  SerialData  output  1  serial sample bit, MSB first
  Underrun  output  1  one-cycle pulse, frame started with FIFO empty

Function
REQ-003 A sample SHALL be written into the FIFO on each rising Clock edge where SampleValid and SampleReady are both 1.
REQ-004 SampleReady SHALL equal 1 whenever the FIFO is not full, combinationally from the occupancy count; push is ignored when full.
REQ-005 Simultaneous push and pop SHALL leave occupancy unchanged; pop never occurs when empty.
REQ-006 The FSM SHALL have states IDLE and SHIFT; reset enters IDLE.
REQ-007 In IDLE: BitClock, WordSelect, SerialData held 0; when FIFO non-empty, pop head into the shift sample, clear counters, go to SHIFT.
REQ-008 Latency: a sample accepted at edge N into an empty FIFO in IDLE SHALL present its MSB on SerialData after edge N+1.
REQ-009 In SHIFT, divider divCnt SHALL count 0..2*CLK_DIV-1 and wrap; BitClock = 1 when divCnt >= CLK_DIV, else 0.
REQ-010 Bit counter bitCnt SHALL count 0..2*WAVE_DEPTH-1, advancing at the edge where divCnt = 2*CLK_DIV-1.
REQ-011 WordSelect SHALL be 1 when bitCnt >= WAVE_DEPTH, else 0.
REQ-012 SerialData SHALL be sample bit [WAVE_DEPTH-1-(bitCnt mod WAVE_DEPTH)]; same sample sent in both slots (mono).
REQ-013 Frame length SHALL be 4*WAVE_DEPTH*CLK_DIV Clock cycles (64 at defaults); SerialData/WordSelect change only while BitClock is low-going (divCnt wrap).
REQ-014 At frame end (bitCnt = 2*WAVE_DEPTH-1, divCnt wrap): FIFO non-empty -> pop next sample; empty -> underrun sample per REQ-020/021 and Underrun = 1 for exactly that cycle's following cycle.
REQ-015 SHIFT SHALL never return to IDLE except via Reset; frames are back-to-back with no gap cycles.

Reset
REQ-016 Reset low SHALL asynchronously force: FIFO empty, FSM IDLE, divCnt/bitCnt 0, shift sample 0, last-sample register 0.
REQ-017 Output reset values SHALL be: SampleReady 1, BitClock 0, WordSelect 0, SerialData 0, Underrun 0.
REQ-018 Reset asserted mid-frame SHALL abort the frame immediately; queued samples are discarded.
REQ-019 Release of Reset SHALL be sampled synchronously; first FSM action at the first rising Clock edge with Reset high.

Configuration
REQ-020 Macro UNDERRUN_HOLD_EN defined: an underrun frame SHALL repeat the last transmitted sample.
REQ-021 Macro UNDERRUN_HOLD_EN undefined: an underrun frame SHALL send midscale 1<<(WAVE_DEPTH-1) (8'h80 at defaults); the last-sample register SHALL be omitted. Underrun pulse behaves identically in both builds.

Verification
REQ-022 Single sample 8'hA5 pushed after reset -> SerialData 1,0,1,0,0,1,0,1 with WordSelect 0, repeated with WordSelect 1; each bit held 4 Clock cycles; MSB visible one cycle after acceptance.
REQ-023 Push 5 samples back-to-back in IDLE at defaults -> first popped, next 4 fill FIFO; SampleReady 0 until first frame-end pop, then 1.
REQ-024 Stream 8'h01, 8'hFF then stop -> third frame Underrun pulses once; sends 8'h80 without UNDERRUN_HOLD_EN, 8'hFF with it.
REQ-025 Reset low at bit 5 of a frame with 3 queued -> outputs return to reset values immediately, SampleReady 1, no SerialData activity until next push.
REQ-026 FIFO at 3 entries, push during frame-end pop -> occupancy stays 3, no sample lost or duplicated across following 4 frames.
